uart_rx_os: RTL and testbench

Parametrised 16550-style serial receiver: a second-generation RX engine with the following features:
- configurable oversampling ratio;
- a metastability synchroniser on `rx`;
- per-frame latching of line control;
- early stop-bit release for back-to-back frames;
- true break detection.

It sits between the baud generator (`baud_pulse` at OSR× bit rate) and the RX FIFO, which it writes via `push`.

---
 rtl/uart_rx_os.sv | 147 ++++++++++++++
 tb/tb_uart_rx_os.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling 16550-style serial receiver with sync, early stop release and break detect.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote per bit around mid-bit.
module uart_rx_os #(
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  output logic       push,
  output logic [7:0] dout,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic       busy
);
  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] TOP = CW'(OSR - 1);
  localparam logic [CW-1:0] MID = CW'(OSR / 2 - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] DEC = CW'(OSR / 2 - 2);
`else
  localparam logic [CW-1:0] DEC = MID;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [3:0]             r_bitcnt;
  logic [7:0]             r_shift;
  logic [1:0]             r_wls;
  logic                   r_pen, r_eps, r_stick, r_pbit, r_perr;
  logic                   w_rx_s, w_bit, w_dec, w_par, w_perr, w_brk;
  logic [7:0]             w_shift;
  assign w_rx_s = r_sync[SYNC_STAGES-1];
`ifdef UART_RX_MAJORITY_EN
  logic r_s1, r_s2;
  assign w_bit = (r_s1 & r_s2) | (r_s1 & w_rx_s) | (r_s2 & w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif
  assign w_dec  = (r_cnt == DEC);
  assign w_par  = ^r_shift ^ w_bit;
  assign w_perr = r_stick ? (w_bit == r_eps) : (w_par ^ ~r_eps);
  assign w_brk  = (r_shift == 8'd0) && !(r_pen && r_pbit) && !w_bit;
  assign busy   = (r_state != IDLE);
  // New bit enters at the top of the configured word so the frame ends LSB-aligned.
  always_comb begin
    w_shift = r_shift >> 1;
    w_shift[r_wls + 3'd4] = w_bit;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '1;
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_wls    <= '0;
      r_pen    <= 1'b0;
      r_eps    <= 1'b0;
      r_stick  <= 1'b0;
      r_pbit   <= 1'b0;
      r_perr   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
`endif
      push     <= 1'b0;
      dout     <= '0;
      pe       <= 1'b0;
      fe       <= 1'b0;
      bi       <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
      push   <= 1'b0;
      if (baud_pulse) begin
`ifdef UART_RX_MAJORITY_EN
        if (r_cnt == MID + 1'b1) r_s1 <= w_rx_s;
        if (r_cnt == MID) r_s2 <= w_rx_s;
`endif
        case (r_state)
          IDLE: if (!w_rx_s) begin
            r_state <= START;
            r_cnt   <= TOP;
          end
          START: begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              r_state  <= DATA;
              r_cnt    <= TOP;
              r_bitcnt <= 4'd5 + 4'(w_dec ? wls : r_wls);
            end
            if (w_dec && w_bit) r_state <= IDLE;
            if (w_dec && !w_bit) begin
              r_wls   <= wls;
              r_pen   <= pen;
              r_eps   <= eps;
              r_stick <= sticky_parity;
              r_shift <= '0;
              r_perr  <= 1'b0;
              r_pbit  <= 1'b0;
            end
          end
          DATA: begin
            r_cnt <= r_cnt - 1'b1;
            if (w_dec) r_shift <= w_shift;
            if (r_cnt == '0) begin
              r_cnt    <= TOP;
              r_bitcnt <= r_bitcnt - 1'b1;
              if (r_bitcnt == 4'd1) r_state <= r_pen ? PARITY : STOP;
            end
          end
          PARITY: begin
            r_cnt <= r_cnt - 1'b1;
            if (w_dec) begin
              r_perr <= w_perr;
              r_pbit <= w_bit;
            end
            if (r_cnt == '0) begin
              r_state <= STOP;
              r_cnt   <= TOP;
            end
          end
          STOP: begin
            r_cnt <= r_cnt - 1'b1;
            if (w_dec) begin
              push    <= 1'b1;
              dout    <= r_shift;
              pe      <= r_perr;
              fe      <= ~w_bit;
              bi      <= w_brk;
              r_state <= w_brk ? BRK : IDLE;
            end
          end
          BRK: if (w_rx_s) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed frame checks for uart_rx_os (one baud tick every 4 clk).
module tb_uart_rx_os;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_pulse;
  logic       rx = 1'b1;
  logic [1:0] wls = 2'b11;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       sticky_parity = 1'b0;
  logic       push, pe, fe, bi, busy;
  logic [7:0] dout;
  logic [1:0] bcnt = 2'd0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_push = 0;
  logic [7:0] log_dout [64];
  logic       was_push = 1'b0;
  logic       busy_after = 1'b1;

  uart_rx_os #(.OSR(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .baud_pulse(baud_pulse), .rx(rx), .wls(wls), .pen(pen),
    .eps(eps), .sticky_parity(sticky_parity), .push(push), .dout(dout), .pe(pe),
    .fe(fe), .bi(bi), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) bcnt <= bcnt + 2'd1;
  assign baud_pulse = (bcnt == 2'd3);

  always @(negedge clk) begin
    if (was_push) busy_after = busy;
    was_push = push;
    if (push) begin
      log_dout[n_push % 64] = dout;
      n_push++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n * 4) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int nb, input bit has_par, input logic pb,
                      input logic sb, input int stop_t, input int idle_t, input bit tog, input int gl);
    rx = 1'b0;
    ticks(16);
    for (int i = 0; i < nb; i++) begin
      if (tog && i == 1) wls = 2'b00;
      if (tog && i == nb - 1) wls = 2'b11;
      rx = d[i];
      if (gl == i) begin
        ticks(8);
        rx = ~d[i];
        ticks(1);
        rx = d[i];
        ticks(7);
      end else ticks(16);
    end
    if (has_par) begin
      rx = pb;
      ticks(16);
    end
    rx = sb;
    ticks(stop_t);
    rx = 1'b1;
    ticks(idle_t);
  endtask

  task automatic frame_chk(input string tag, input int base, input logic [7:0] d,
                           input logic p, input logic f, input logic b);
    chk({tag, "_npush"}, n_push - base, 1);
    chk({tag, "_dout"}, dout, d);
    chk({tag, "_pe"}, pe, p);
    chk({tag, "_fe"}, fe, f);
    chk({tag, "_bi"}, bi, b);
  endtask

  initial begin
    int base;
    ticks(2);
    chk("rst_outs", {push, dout, pe, fe, bi, busy}, 13'd0);
    @(negedge clk) rst_n = 1'b1;
    ticks(4);
    chk("idle_busy", busy, 0);

    base = n_push;
    send(8'hA5, 8, 0, 0, 1, 16, 20, 0, -1);
    frame_chk("8n1_a5", base, 8'hA5, 0, 0, 0);
    chk("8n1_busy_after", busy_after, 0);

    wls = 2'b10; pen = 1'b1; eps = 1'b1; sticky_parity = 1'b0;
    base = n_push;
    send(8'h41, 7, 1, 1, 1, 16, 20, 0, -1);
    frame_chk("7e1_bad", base, 8'h41, 1, 0, 0);

    wls = 2'b00; sticky_parity = 1'b1; eps = 1'b1;
    base = n_push;
    send(8'h1F, 5, 1, 0, 1, 16, 20, 0, -1);
    frame_chk("5s_ok", base, 8'h1F, 0, 0, 0);

    eps = 1'b0;
    base = n_push;
    send(8'h1F, 5, 1, 0, 1, 16, 20, 0, -1);
    frame_chk("5s_bad", base, 8'h1F, 1, 0, 0);

    wls = 2'b11; sticky_parity = 1'b0; eps = 1'b0;
    base = n_push;
    send(8'h03, 8, 1, 0, 1, 16, 20, 0, -1);
    frame_chk("8o1_bad", base, 8'h03, 1, 0, 0);
    base = n_push;
    send(8'h03, 8, 1, 1, 1, 16, 20, 0, -1);
    frame_chk("8o1_ok", base, 8'h03, 0, 0, 0);

    pen = 1'b0;
    base = n_push;
    send(8'h3C, 8, 0, 0, 0, 16, 20, 0, -1);
    frame_chk("stop0", base, 8'h3C, 0, 1, 0);

    base = n_push;
    rx = 1'b0;
    ticks(320);
    frame_chk("brk", base, 8'h00, 0, 1, 1);
    chk("brk_busy", busy, 1);
    rx = 1'b1;
    ticks(20);
    chk("brk_release_busy", busy, 0);
    chk("brk_no_more_push", n_push - base, 1);

    base = n_push;
    rx = 1'b0;
    ticks(4);
    rx = 1'b1;
    ticks(20);
    chk("glitch_npush", n_push - base, 0);
    chk("glitch_busy", busy, 0);

`ifdef UART_RX_MAJORITY_EN
    base = n_push;
    send(8'h55, 8, 0, 0, 1, 16, 20, 0, 2);
    frame_chk("maj_55", base, 8'h55, 0, 0, 0);
`endif

    base = n_push;
    send(8'h12, 8, 0, 0, 1, 14, 0, 1, -1);
    send(8'h34, 8, 0, 0, 1, 16, 20, 0, -1);
    chk("b2b_npush", n_push - base, 2);
    chk("b2b_first", log_dout[base % 64], 8'h12);
    chk("b2b_second", log_dout[(base + 1) % 64], 8'h34);
    chk("b2b_fe", fe, 0);

    base = n_push;
    rx = 1'b0;
    ticks(16);
    rx = 1'b1;
    ticks(48);
    rx = 1'b0;
    ticks(8);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {push, dout, pe, fe, bi, busy}, 13'd0);
    rx = 1'b1;
    ticks(2);
    @(negedge clk) rst_n = 1'b1;
    ticks(10);
    chk("midrst_npush", n_push - base, 0);
    base = n_push;
    send(8'h7E, 8, 0, 0, 1, 16, 20, 0, -1);
    frame_chk("post_rst_7e", base, 8'h7E, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
